// File: rtl/bb_uart_baudgen.sv
// bb_uart_baudgen - UART baud-rate generator for the ispMACH 4256ZE breakout.
// Divides the 5 MHz oscillator clock into an oversample tick, a mid-bit tick,
// an end-of-bit tick and a 50% duty bit-rate square wave.
// Optional fractional divisor: define BAUD_FRAC_EN to add the div_frac port
// and a 1/16-step accumulator that stretches selected oversample periods.
module bb_uart_baudgen #(
  parameter int CNT_W     = 12,
  parameter int OVS       = 16,
  parameter int DIV_RESET = 31
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             restart,
  input  logic [CNT_W-1:0] div_int,
`ifdef BAUD_FRAC_EN
  input  logic [3:0]       div_frac,
`endif
  output logic             ovs_tick,
  output logic             bit_tick,
  output logic             mid_tick,
  output logic             bd_clk
);

  localparam int OVS_W = $clog2(OVS);
  localparam logic [OVS_W-1:0] OVS_LAST = OVS_W'(OVS - 1);
  localparam logic [OVS_W-1:0] OVS_MID  = OVS_W'(OVS / 2 - 1);

  logic [CNT_W-1:0] pre_cnt;
  logic [OVS_W-1:0] ovs_cnt;
  logic [CNT_W-1:0] div_sh;
  logic             bd_reg;
  logic [CNT_W-1:0] div_eff;
  logic [CNT_W-1:0] term_cnt;
  logic             run;

`ifdef BAUD_FRAC_EN
  logic [3:0] frac_acc;
  logic [3:0] frac_sh;
  logic       ext;
  logic [4:0] frac_sum;
`endif

  // Divisor 0 would make the prefix counter terminate every cycle; clamp to 1
  // so the shortest oversample period is two cycles.
  always_comb begin
    div_eff = (div_sh == '0) ? CNT_W'(1) : div_sh;
`ifdef BAUD_FRAC_EN
    term_cnt = div_eff + CNT_W'(ext);
    frac_sum = {1'b0, frac_acc} + {1'b0, frac_sh};
`else
    term_cnt = div_eff;
`endif
  end

  // Tick decode from registered state; suppressed by reset, disable and restart.
  always_comb begin
    run      = en & ~rst & ~restart;
    ovs_tick = run & (pre_cnt == term_cnt);
    mid_tick = ovs_tick & (ovs_cnt == OVS_MID);
    bit_tick = ovs_tick & (ovs_cnt == OVS_LAST);
    bd_clk   = bd_reg & en & ~rst;
  end

  // Prescaler, oversample counter, square wave and shadow divisor.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt <= '0;
      ovs_cnt <= '0;
      bd_reg  <= 1'b0;
      div_sh  <= CNT_W'(DIV_RESET);
    end else if (!en) begin
      pre_cnt <= '0;
      ovs_cnt <= '0;
      bd_reg  <= 1'b0;
      div_sh  <= div_int;
    end else if (restart) begin
      pre_cnt <= '0;
      ovs_cnt <= '0;
      bd_reg  <= 1'b0;
    end else begin
      if (ovs_tick) begin
        pre_cnt <= '0;
        ovs_cnt <= ovs_cnt + 1'b1;   // OVS is a power of 2: natural wrap
      end else begin
        pre_cnt <= pre_cnt + 1'b1;
      end
      if (mid_tick)      bd_reg <= 1'b1;
      else if (bit_tick) bd_reg <= 1'b0;
      // New divisor only takes effect at a bit boundary
      if (bit_tick)      div_sh <= div_int;
    end
  end

`ifdef BAUD_FRAC_EN
  // Fractional accumulator: each carry stretches the next oversample period by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      frac_acc <= '0;
      ext      <= 1'b0;
      frac_sh  <= '0;
    end else if (!en) begin
      frac_acc <= '0;
      ext      <= 1'b0;
      frac_sh  <= div_frac;
    end else if (restart) begin
      frac_acc <= '0;
      ext      <= 1'b0;
    end else begin
      if (ovs_tick) begin
        frac_acc <= frac_sum[3:0];
        ext      <= frac_sum[4];
      end
      if (bit_tick) frac_sh <= div_frac;
    end
  end
`endif

endmodule
